// File: rtl/dco_loop_filter.sv
// PI loop filter for the ADPLL: signed phase error in, unsigned DCO tuning word out.
// Optional macro DCO_LOOP_FILTER_GEAR_EN: boosted gains in ACQUIRE, integrator rescale on lock.
module dco_loop_filter #(
    parameter int                ERR_W       = 8,
    parameter int                WORD_W      = 16,
    parameter int                KP_SHIFT    = 2,
    parameter int                KI_SHIFT    = 6,
    parameter logic [WORD_W-1:0] CENTRE      = 16'h8000,
    parameter int                LOCK_THRESH = 4,
    parameter int                LOCK_COUNT  = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic signed [ERR_W-1:0] error_i,
    input  logic                    error_valid_i,
    input  logic                    freeze_i,
    output logic [WORD_W-1:0]       tune_word_o,
    output logic                    tune_valid_o,
    output logic                    locked_o,
    output logic                    saturated_o
);
    localparam int INT_W = WORD_W + KI_SHIFT;
`ifdef DCO_LOOP_FILTER_GEAR_EN
    localparam int SUM_W = WORD_W + 3;
`else
    localparam int SUM_W = WORD_W + 2;
`endif
    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam logic signed [INT_W:0] IMAX = {2'b00, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W:0] IMIN = -IMAX;
    localparam logic [ERR_W:0] TH1 = (ERR_W+1)'(LOCK_THRESH);
    localparam logic [ERR_W:0] TH2 = (ERR_W+1)'(2 * LOCK_THRESH);
    localparam logic [CNT_W-1:0] LCNT = CNT_W'(LOCK_COUNT);

    typedef enum logic [1:0] {ACQUIRE, TRACK, HOLD} state_t;

    logic signed [ERR_W-1:0] r_e;
    logic                    r_v;
    logic                    r_f;
    logic signed [INT_W-1:0] r_integ;
    logic [WORD_W-1:0]       r_word;
    logic                    r_tv;
    logic                    r_lock;
    logic                    r_hi;
    logic                    r_lo;
    logic [CNT_W-1:0]        r_cnt;
    state_t                  r_state;
    state_t                  r_ret;

    logic [ERR_W:0]          w_abs;
    logic                    w_upd;
    logic                    w_blk;
    logic signed [INT_W:0]   w_isum;
    logic signed [INT_W-1:0] w_integ;
    logic signed [INT_W-1:0] w_integ_q;
    logic signed [SUM_W-1:0] w_prop;
    logic signed [SUM_W-1:0] w_itm;
    logic signed [SUM_W-1:0] w_sum;
    logic [WORD_W-1:0]       w_word;
    logic                    w_hi;
    logic                    w_lo;
    logic [CNT_W-1:0]        w_cnt;
    state_t                  w_base;
    state_t                  w_base_n;
    state_t                  w_state_n;
    state_t                  w_ret_n;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v <= 1'b0;
            r_e <= '0;
            r_f <= 1'b0;
        end else begin
            r_v <= error_valid_i;
            if (error_valid_i) begin
                r_e <= error_i;
                r_f <= freeze_i;
            end
        end
    end

    // Frozen samples skip the integrator and drop the proportional path.
    always_comb begin
        w_abs  = r_e[ERR_W-1] ? -{r_e[ERR_W-1], r_e} : {1'b0, r_e};
        w_upd  = r_v & ~r_f;
        w_base = (r_state == HOLD) ? r_ret : r_state;
        w_blk  = (r_hi & ~r_e[ERR_W-1]) | (r_lo & r_e[ERR_W-1]);
        w_isum = {r_integ[INT_W-1], r_integ}
               + {{(INT_W+1-ERR_W){r_e[ERR_W-1]}}, r_e};
        w_integ = r_integ;
        if (w_upd && !w_blk) begin
            if (w_isum > IMAX)
                w_integ = IMAX[INT_W-1:0];
            else if (w_isum < IMIN)
                w_integ = IMIN[INT_W-1:0];
            else
                w_integ = w_isum[INT_W-1:0];
        end
        w_prop = '0;
        if (!r_f)
            w_prop = {{(SUM_W-ERR_W-KP_SHIFT){r_e[ERR_W-1]}}, r_e,
                      {KP_SHIFT{1'b0}}};
        w_itm = {{(SUM_W-WORD_W){w_integ[INT_W-1]}},
                 w_integ[INT_W-1:KI_SHIFT]};
`ifdef DCO_LOOP_FILTER_GEAR_EN
        if (!r_f && w_base == ACQUIRE) begin
            w_prop = {{(SUM_W-ERR_W-KP_SHIFT-1){r_e[ERR_W-1]}}, r_e,
                      {(KP_SHIFT+1){1'b0}}};
            w_itm  = {{(SUM_W-WORD_W-2){w_integ[INT_W-1]}},
                      w_integ[INT_W-1:KI_SHIFT-2]};
        end
`endif
        w_sum  = {{(SUM_W-WORD_W){1'b0}}, CENTRE} + w_prop + w_itm;
        w_word = w_sum[WORD_W-1:0];
        w_hi   = 1'b0;
        w_lo   = 1'b0;
        if (w_sum[SUM_W-1]) begin
            w_word = '0;
            w_lo   = 1'b1;
        end else if (|w_sum[SUM_W-2:WORD_W]) begin
            w_word = '1;
            w_hi   = 1'b1;
        end
        w_cnt = r_cnt;
        if (w_upd) begin
            if (w_abs > TH1)
                w_cnt = '0;
            else if (r_cnt != LCNT)
                w_cnt = r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_base_n = w_base;
        if (w_upd) begin
            unique case (w_base)
                ACQUIRE: if (w_cnt == LCNT) w_base_n = TRACK;
                TRACK:   if (w_abs > TH2) w_base_n = ACQUIRE;
                default: w_base_n = ACQUIRE;
            endcase
        end
        w_state_n = freeze_i ? HOLD : w_base_n;
        w_ret_n   = freeze_i ? w_base_n : r_ret;
        w_integ_q = w_integ;
`ifdef DCO_LOOP_FILTER_GEAR_EN
        if (w_base == ACQUIRE && w_base_n == TRACK)
            w_integ_q = w_integ >>> 2;
`endif
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ACQUIRE;
            r_ret   <= ACQUIRE;
        end else begin
            r_state <= w_state_n;
            r_ret   <= w_ret_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_integ <= '0;
            r_word  <= CENTRE;
            r_tv    <= 1'b0;
            r_lock  <= 1'b0;
            r_hi    <= 1'b0;
            r_lo    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_integ <= w_integ_q;
            r_cnt   <= w_cnt;
            r_tv    <= r_v;
            r_lock  <= (w_base_n == TRACK);
            if (r_v) begin
                r_word <= w_word;
                r_hi   <= w_hi;
                r_lo   <= w_lo;
            end
        end
    end

    assign tune_word_o  = r_word;
    assign tune_valid_o = r_tv;
    assign locked_o     = r_lock;
    assign saturated_o  = r_hi | r_lo;
endmodule

// File: tb/tb_dco_loop_filter.sv
// Testbench for dco_loop_filter: directed scenarios plus randomized traffic
// checked against an integer-arithmetic model of the PI filter and lock rules.
module tb_dco_loop_filter;
    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic signed [7:0] error_i;
    logic              error_valid_i;
    logic              freeze_i;
    logic [15:0]       tune_word_o;
    logic              tune_valid_o;
    logic              locked_o;
    logic              saturated_o;

    dco_loop_filter dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .error_i(error_i),
        .error_valid_i(error_valid_i),
        .freeze_i(freeze_i),
        .tune_word_o(tune_word_o),
        .tune_valid_o(tune_valid_o),
        .locked_o(locked_o),
        .saturated_o(saturated_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    longint      m_integ;
    int          m_satp;
    int          m_cnt;
    bit          m_track;
    logic [15:0] exp_word;
    bit          exp_v, exp_lock, exp_sat;
    bit          s1_v, s1_f;
    int          s1_e;

    function automatic void model_reset();
        m_integ = 0; m_satp = 0; m_cnt = 0; m_track = 0;
        exp_word = 16'h8000; exp_v = 0; exp_lock = 0; exp_sat = 0;
        s1_v = 0; s1_f = 0; s1_e = 0;
    endfunction

    // One processed sample: integrate, form PI sum, clip, then lock rules.
    function automatic void model_apply(input int e, input bit f);
        longint lim = (longint'(1) << 21) - 1;
        longint out;
        int kp = 2;
        int ki = 6;
        int a = (e < 0) ? -e : e;
        bit acq = !m_track;
        if (!f) begin
            if (!((m_satp > 0 && e >= 0) || (m_satp < 0 && e < 0))) begin
                m_integ = m_integ + e;
                if (m_integ > lim) m_integ = lim;
                if (m_integ < -lim) m_integ = -lim;
            end
`ifdef DCO_LOOP_FILTER_GEAR_EN
            if (acq) begin kp = 3; ki = 4; end
`endif
        end
        out = 32768 + (f ? 0 : e * (1 << kp)) + (m_integ >>> ki);
        if (out < 0) begin
            exp_word = 16'h0000; m_satp = -1;
        end else if (out > 65535) begin
            exp_word = 16'hFFFF; m_satp = 1;
        end else begin
            exp_word = 16'(out); m_satp = 0;
        end
        exp_sat = (m_satp != 0);
        if (!f) begin
            m_cnt = (a <= 4) ? ((m_cnt < 16) ? m_cnt + 1 : 16) : 0;
            if (acq && m_cnt == 16) begin
                m_track = 1;
`ifdef DCO_LOOP_FILTER_GEAR_EN
                m_integ = m_integ >>> 2;
`endif
            end else if (m_track && a > 8) begin
                m_track = 0;
            end
        end
        exp_lock = m_track;
    endfunction

    task automatic tick(input int e, input bit v, input bit f);
        error_i = 8'(e);
        error_valid_i = v;
        freeze_i = f;
        @(posedge clk_i);
        #1;
        exp_v = s1_v;
        if (s1_v) model_apply(s1_e, s1_f);
        s1_v = v; s1_e = e; s1_f = f;
    endtask

    task automatic do_reset();
        error_i = 0; error_valid_i = 0; freeze_i = 0;
        reset_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (tune_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b want=0", tune_valid_o); end
        n_cmp++; if (tune_word_o !== 16'h8000) begin n_bad++; $display("FAIL rst_word got=%h want=8000", tune_word_o); end
        n_cmp++; if (locked_o !== 1'b0) begin n_bad++; $display("FAIL rst_lock got=%b want=0", locked_o); end
        n_cmp++; if (saturated_o !== 1'b0) begin n_bad++; $display("FAIL rst_sat got=%b want=0", saturated_o); end
    endtask

    task automatic test_single();
        do_reset();
        tick(10, 1, 0);
        n_cmp++; if (tune_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_early got=%b want=0", tune_valid_o); end
        tick(0, 0, 0);
        n_cmp++; if (tune_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b want=1", tune_valid_o); end
        n_cmp++; if (tune_word_o !== 16'h8028) begin n_bad++; $display("FAIL single_word got=%h want=8028", tune_word_o); end
        tick(0, 1, 0);
        n_cmp++; if (tune_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_pulse got=%b want=0", tune_valid_o); end
        tick(0, 0, 0);
        n_cmp++; if (tune_word_o !== 16'h8000) begin n_bad++; $display("FAIL single_zero got=%h want=8000", tune_word_o); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] want;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick((i < 3) ? 64 : 0, i < 3, 0);
            if (i >= 1 && i <= 3) begin
                want = 16'h8100 + 16'(i);
                n_cmp++; if (tune_valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d] got=%b want=1", i, tune_valid_o); end
                n_cmp++; if (tune_word_o !== want) begin n_bad++; $display("FAIL b2b_word[%0d] got=%h want=%h", i, tune_word_o, want); end
            end else if (i == 4) begin
                n_cmp++; if (tune_valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_end got=%b want=0", tune_valid_o); end
            end
        end
    endtask

    task automatic test_saturation();
        int n = 0;
        do_reset();
        while (exp_word != 16'hFFFF && n < 20000) begin
            tick(127, 1, 0);
            n++;
        end
        n_cmp++; if (n >= 20000) begin n_bad++; $display("FAIL sat_reach got=%0d want<20000", n); end
        repeat (8) tick(127, 1, 0);
        tick(-127, 1, 0);
        n_cmp++; if (tune_word_o !== 16'hFFFF) begin n_bad++; $display("FAIL sat_word got=%h want=ffff", tune_word_o); end
        n_cmp++; if (saturated_o !== 1'b1) begin n_bad++; $display("FAIL sat_flag got=%b want=1", saturated_o); end
        tick(0, 0, 0);
        n_cmp++; if (tune_word_o !== exp_word) begin n_bad++; $display("FAIL sat_leave got=%h want=%h", tune_word_o, exp_word); end
        n_cmp++; if (tune_word_o === 16'hFFFF) begin n_bad++; $display("FAIL sat_stuck got=%h want!=ffff", tune_word_o); end
        n_cmp++; if (saturated_o !== 1'b0) begin n_bad++; $display("FAIL sat_clear got=%b want=0", saturated_o); end
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            tick((i < 16) ? 3 : 0, i < 16, 0);
            if (i >= 1) begin
                n_cmp++; if (locked_o !== (i == 16)) begin n_bad++; $display("FAIL lock_rise[%0d] got=%b want=%b", i, locked_o, i == 16); end
            end
        end
        tick(6, 1, 0);
        tick(0, 0, 0);
        n_cmp++; if (locked_o !== 1'b1) begin n_bad++; $display("FAIL lock_hyst got=%b want=1", locked_o); end
        tick(9, 1, 0);
        tick(0, 0, 0);
        n_cmp++; if (locked_o !== 1'b0) begin n_bad++; $display("FAIL lock_fall got=%b want=0", locked_o); end
        n_cmp++; if (tune_word_o !== exp_word) begin n_bad++; $display("FAIL lock_word got=%h want=%h", tune_word_o, exp_word); end
    endtask

    task automatic test_hold();
        do_reset();
        repeat (6) tick(96, 1, 0);
        repeat (16) tick(4, 1, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        n_cmp++; if (locked_o !== 1'b1) begin n_bad++; $display("FAIL hold_pre_lock got=%b want=1", locked_o); end
        n_cmp++; if (tune_word_o !== 16'h801A) begin n_bad++; $display("FAIL hold_pre_word got=%h want=801a", tune_word_o); end
        tick(100, 1, 1);
        tick(0, 0, 1);
        n_cmp++; if (tune_valid_o !== 1'b1) begin n_bad++; $display("FAIL hold_valid got=%b want=1", tune_valid_o); end
        n_cmp++; if (tune_word_o !== 16'h800A) begin n_bad++; $display("FAIL hold_word got=%h want=800a", tune_word_o); end
        n_cmp++; if (locked_o !== 1'b1) begin n_bad++; $display("FAIL hold_lock got=%b want=1", locked_o); end
        tick(0, 0, 0);
        tick(0, 1, 0);
        tick(0, 0, 0);
        n_cmp++; if (tune_word_o !== 16'h800A) begin n_bad++; $display("FAIL hold_resume got=%h want=800a", tune_word_o); end
        tick(20, 1, 0);
        tick(0, 0, 0);
        n_cmp++; if (tune_word_o !== 16'h805A) begin n_bad++; $display("FAIL hold_track got=%h want=805a", tune_word_o); end
        n_cmp++; if (locked_o !== 1'b0) begin n_bad++; $display("FAIL hold_unlock got=%b want=0", locked_o); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        repeat (16) tick(3, 1, 0);
        tick(0, 0, 0);
        tick(64, 1, 0);
        n_cmp++; if (locked_o !== 1'b1) begin n_bad++; $display("FAIL midrst_pre got=%b want=1", locked_o); end
        error_valid_i = 0;
        #2 reset_n_i = 1'b0;
        #1;
        n_cmp++; if (locked_o !== 1'b0) begin n_bad++; $display("FAIL midrst_async got=%b want=0", locked_o); end
        #1 reset_n_i = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0);
            n_cmp++; if (tune_valid_o !== 1'b0) begin n_bad++; $display("FAIL midrst_valid[%0d] got=%b want=0", i, tune_valid_o); end
            n_cmp++; if (tune_word_o !== 16'h8000) begin n_bad++; $display("FAIL midrst_word[%0d] got=%h want=8000", i, tune_word_o); end
            n_cmp++; if (locked_o !== 1'b0) begin n_bad++; $display("FAIL midrst_lock[%0d] got=%b want=0", i, locked_o); end
        end
    endtask

    task automatic test_random();
        bit frz = 0;
        int e, sel;
        bit v;
        do_reset();
        for (int i = 0; i < 3002; i++) begin
            if ($urandom_range(0, 31) == 0) frz = !frz;
            v = (i < 3000) && ($urandom_range(0, 3) != 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 7) e = int'($urandom_range(0, 16)) - 8;
            else if (sel < 9) e = int'($urandom_range(0, 255)) - 128;
            else e = ($urandom_range(0, 1) != 0) ? -128 : 127;
            tick(e, v, frz);
            n_cmp++; if (tune_valid_o !== exp_v) begin n_bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", i, tune_valid_o, exp_v); end
            if (exp_v) begin
                n_cmp++; if (tune_word_o !== exp_word) begin n_bad++; $display("FAIL rnd_word[%0d] got=%h want=%h", i, tune_word_o, exp_word); end
                n_cmp++; if (locked_o !== exp_lock) begin n_bad++; $display("FAIL rnd_lock[%0d] got=%b want=%b", i, locked_o, exp_lock); end
                n_cmp++; if (saturated_o !== exp_sat) begin n_bad++; $display("FAIL rnd_sat[%0d] got=%b want=%b", i, saturated_o, exp_sat); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n_i = 1'b0;
        error_i = 0;
        error_valid_i = 0;
        freeze_i = 0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_lock();
        test_hold();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
